// File: rtl/cube_scan_sequencer.sv
// -----------------------------------------------------------------------------
// cube_scan_sequencer
//
// Steps through every non-center sticker of the cube. For each sticker it:
//   1. requests that sticker's setup-move sequence from the motor sequencer,
//   2. waits for the turn to complete, then for a settle period,
//   3. samples the color sensor channel that serves the sticker, and
//   4. accepts the color after AGREE_COUNT consecutive identical legal readings.
// Accepted colors are packed into a flat cube-state register for the solver.
// If a sticker cannot be agreed on within SAMPLE_TIMEOUT sample cycles, the
// scan stops in an error state with the cube state and index frozen.
//
// Ports:
//   clock            in   system clock
//   reset            in   synchronous, active-high reset
//   start            in   begins a scan (honored only when not busy)
//   done_turning     in   motor sequence complete (looked at only while waiting)
//   color_sensors    in   channel k at [k*COLOR_W +: COLOR_W]
//   send_setup_moves out  one-cycle request pulse to the motor sequencer
//   setup_index      out  sticker whose setup sequence is requested
//   sticker_valid    out  one-cycle pulse when a sticker is written
//   sticker_index    out  current sticker index
//   cubestate        out  sticker i at [i*COLOR_W +: COLOR_W]
//   busy             out  high while a scan is in progress
//   scan_done        out  level, high once every sticker has been read
//   scan_error       out  level, high after a sample timeout
// -----------------------------------------------------------------------------
module cube_scan_sequencer #(
    parameter int NUM_SENSORS         = 2,
    parameter int STICKERS_PER_SENSOR = 24,
    parameter int COLOR_W             = 3,
    parameter int MAX_COLOR           = 5,
    parameter int SETTLE_CYCLES       = 16,
    parameter int AGREE_COUNT         = 4,
    parameter int SAMPLE_TIMEOUT      = 1024,
    localparam int NUM_STICKERS       = NUM_SENSORS * STICKERS_PER_SENSOR,
    localparam int IDX_W              = (NUM_STICKERS > 1) ? $clog2(NUM_STICKERS) : 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            done_turning,
    input  logic [NUM_SENSORS*COLOR_W-1:0]  color_sensors,
    output logic                            send_setup_moves,
    output logic [IDX_W-1:0]                setup_index,
    output logic                            sticker_valid,
    output logic [IDX_W-1:0]                sticker_index,
    output logic [NUM_STICKERS*COLOR_W-1:0] cubestate,
    output logic                            busy,
    output logic                            scan_done,
    output logic                            scan_error
);

    localparam int CUBE_W = NUM_STICKERS * COLOR_W;
    // Settle counter holds 0 .. SETTLE_CYCLES-1.
    localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int AGR_W  = $clog2(AGREE_COUNT + 1);
    localparam int TMO_W  = $clog2(SAMPLE_TIMEOUT + 1);

    // SETTLE_CYCLES of 0 or 1 both give a single pass through SETTLE.
    localparam logic [SET_W-1:0]   SETTLE_LAST = (SETTLE_CYCLES > 1) ? SET_W'(SETTLE_CYCLES - 1)
                                                                     : {SET_W{1'b0}};
    localparam logic [AGR_W-1:0]   AGREE_LAST  = AGR_W'(AGREE_COUNT);
    localparam logic [TMO_W-1:0]   TMO_LAST    = TMO_W'(SAMPLE_TIMEOUT);
    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_STICKERS - 1);
    localparam logic [COLOR_W-1:0] MAX_C       = COLOR_W'(MAX_COLOR);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PREP      = 3'd1,
        ST_WAIT_TURN = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_SAMPLE    = 3'd4,
        ST_WRITE     = 3'd5,
        ST_DONE      = 3'd6,
        ST_ERROR     = 3'd7
    } state_t;

    state_t             state_q,     state_d;
    logic [IDX_W-1:0]   index_q,     index_d;
    logic [SET_W-1:0]   settle_q,    settle_d;
    logic [AGR_W-1:0]   agree_q,     agree_d;
    logic [TMO_W-1:0]   tmo_q,       tmo_d;
    logic [COLOR_W-1:0] held_q,      held_d;
    logic [CUBE_W-1:0]  cube_q,      cube_d;
    logic               send_q,      send_d;
    logic [IDX_W-1:0]   setup_idx_q, setup_idx_d;
    logic               valid_q,     valid_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic               error_q,     error_d;

    logic [COLOR_W-1:0] sample_s;

    // Select the sensor channel serving the current sticker; the last channel
    // whose first sticker is at or below the index wins, which avoids a divider.
    always_comb begin
        sample_s = color_sensors[COLOR_W-1:0];
        for (int k = 1; k < NUM_SENSORS; k++) begin
            sample_s = (index_q >= IDX_W'(k * STICKERS_PER_SENSOR))
                       ? color_sensors[k*COLOR_W +: COLOR_W] : sample_s;
        end
    end

    // Next-state and datapath logic for the scan FSM.
    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        settle_d = settle_q;
        agree_d  = agree_q;
        tmo_d    = tmo_q;
        held_d   = held_q;
        cube_d   = cube_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    cube_d  = {CUBE_W{1'b0}};
                    index_d = {IDX_W{1'b0}};
                    state_d = ST_PREP;
                end else begin
                    state_d = state_q;
                end
            end
            ST_PREP: begin
                settle_d = {SET_W{1'b0}};
                agree_d  = {AGR_W{1'b0}};
                tmo_d    = {TMO_W{1'b0}};
                state_d  = ST_WAIT_TURN;
            end
            ST_WAIT_TURN: begin
                if (done_turning) begin
                    settle_d = {SET_W{1'b0}};
                    state_d  = ST_SETTLE;
                end else begin
                    state_d  = state_q;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    agree_d = {AGR_W{1'b0}};
                    tmo_d   = {TMO_W{1'b0}};
                    state_d = ST_SAMPLE;
                end else begin
                    settle_d = settle_q + SET_W'(1'b1);
                end
            end
            ST_SAMPLE: begin
                tmo_d = tmo_q + TMO_W'(1'b1);
                // Illegal codes break any run in progress.
                if (sample_s > MAX_C) begin
                    agree_d = {AGR_W{1'b0}};
                end else if ((agree_q != {AGR_W{1'b0}}) && (sample_s == held_q)) begin
                    agree_d = agree_q + AGR_W'(1'b1);
                end else begin
                    held_d  = sample_s;
                    agree_d = AGR_W'(1'b1);
                end
                // Agreement on the last allowed sample still counts as success.
                if (agree_d == AGREE_LAST) begin
                    for (int i = 0; i < NUM_STICKERS; i++) begin
                        if (index_q == IDX_W'(i)) begin
                            cube_d[i*COLOR_W +: COLOR_W] = held_d;
                        end else begin
                            cube_d[i*COLOR_W +: COLOR_W] = cube_q[i*COLOR_W +: COLOR_W];
                        end
                    end
                    state_d = ST_WRITE;
                end else if (tmo_d == TMO_LAST) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = state_q;
                end
            end
            ST_WRITE: begin
                if (index_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    index_d = index_q + IDX_W'(1'b1);
                    state_d = ST_PREP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state
    // they describe once registered.
    always_comb begin
        send_d      = (state_d == ST_PREP);
        setup_idx_d = index_d;
        valid_d     = (state_d == ST_WRITE);
        busy_d      = (state_d != ST_IDLE) && (state_d != ST_DONE) && (state_d != ST_ERROR);
        done_d      = (state_d == ST_DONE);
        error_d     = (state_d == ST_ERROR);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            index_q     <= {IDX_W{1'b0}};
            settle_q    <= {SET_W{1'b0}};
            agree_q     <= {AGR_W{1'b0}};
            tmo_q       <= {TMO_W{1'b0}};
            held_q      <= {COLOR_W{1'b0}};
            cube_q      <= {CUBE_W{1'b0}};
            send_q      <= 1'b0;
            setup_idx_q <= {IDX_W{1'b0}};
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            settle_q    <= settle_d;
            agree_q     <= agree_d;
            tmo_q       <= tmo_d;
            held_q      <= held_d;
            cube_q      <= cube_d;
            send_q      <= send_d;
            setup_idx_q <= setup_idx_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign send_setup_moves = send_q;
    assign setup_index      = setup_idx_q;
    assign sticker_valid    = valid_q;
    assign sticker_index    = index_q;
    assign cubestate        = cube_q;
    assign busy             = busy_q;
    assign scan_done        = done_q;
    assign scan_error       = error_q;

endmodule

// File: tb/tb_cube_scan_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for cube_scan_sequencer (small configuration: 2 sensors x 2
// stickers, settle 2, agree 3, sample timeout 8).
// A stimulus process plays motor and sensors; expected pulses and sticker
// writes go into queues that a separate monitor pops when the DUT emits them.
// -----------------------------------------------------------------------------
module tb_cube_scan_sequencer;

    localparam int N_SENS = 2;
    localparam int SPS    = 2;
    localparam int C_W    = 3;
    localparam int MAX_C  = 5;
    localparam int SETTLE = 2;
    localparam int A_CNT  = 3;
    localparam int T_OUT  = 8;
    localparam int NS     = N_SENS * SPS;
    localparam int IDX_W  = 2;
    localparam int CS_W   = N_SENS * C_W;
    localparam int CUBE_W = NS * C_W;

    localparam int M_DIR   = 0;
    localparam int M_RAND  = 1;
    localparam int M_NOISY = 2;
    localparam int M_TMO   = 3;
    localparam int M_RST   = 4;
    localparam int M_CLEAN = 5;

    typedef struct {
        int idx;
        int cyc;
    } pulse_t;

    typedef struct {
        int                idx;
        int                cyc;
        logic [CUBE_W-1:0] cube;
    } valid_t;

    logic              clock;
    logic              reset;
    logic              start;
    logic              done_turning;
    logic [CS_W-1:0]   color_sensors;
    logic              send_setup_moves;
    logic [IDX_W-1:0]  setup_index;
    logic              sticker_valid;
    logic [IDX_W-1:0]  sticker_index;
    logic [CUBE_W-1:0] cubestate;
    logic              busy;
    logic              scan_done;
    logic              scan_error;

    int     cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    int     model_cube [NS];
    int     noisy_seq [T_OUT] = '{2, 2, 7, 2, 3, 3, 3, 0};
    pulse_t exp_pulse_q[$];
    valid_t exp_valid_q[$];

    cube_scan_sequencer #(
        .NUM_SENSORS        (N_SENS),
        .STICKERS_PER_SENSOR(SPS),
        .COLOR_W            (C_W),
        .MAX_COLOR          (MAX_C),
        .SETTLE_CYCLES      (SETTLE),
        .AGREE_COUNT        (A_CNT),
        .SAMPLE_TIMEOUT     (T_OUT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .done_turning    (done_turning),
        .color_sensors   (color_sensors),
        .send_setup_moves(send_setup_moves),
        .setup_index     (setup_index),
        .sticker_valid   (sticker_valid),
        .sticker_index   (sticker_index),
        .cubestate       (cubestate),
        .busy            (busy),
        .scan_done       (scan_done),
        .scan_error      (scan_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cycle n is the interval after the n-th rising edge.
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: a sticker is accepted at the first sample that closes a
    // window of A_CNT identical legal readings; no such window -> timeout.
    function automatic void model_eval(input int s [T_OUT], output int val, output int n);
        val = 0;
        n   = 0;
        for (int j = A_CNT - 1; j < T_OUT; j++) begin
            bit ok;
            ok = 1'b1;
            for (int k = 0; k < A_CNT; k++) begin
                if (s[j-k] > MAX_C || s[j-k] != s[j]) ok = 1'b0;
            end
            if (ok && n == 0) begin
                val = s[j];
                n   = j + 1;
            end
        end
    endfunction

    function automatic logic [CUBE_W-1:0] build_cube();
        logic [CUBE_W-1:0] c;
        c = '0;
        for (int i = 0; i < NS; i++) c[i*C_W +: C_W] = C_W'(model_cube[i]);
        return c;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT emits a pulse.
    always @(negedge clock) begin
        pulse_t pe;
        valid_t ve;
        if (send_setup_moves) begin
            if (exp_pulse_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: setup_index=%0d at cycle %0d, none required", setup_index, cyc);
            end else begin
                pe = exp_pulse_q.pop_front();
                check("pulse_index", 64'(setup_index), 64'(pe.idx));
                check("pulse_cycle", 64'(cyc), 64'(pe.cyc));
            end
        end
        if (sticker_valid) begin
            if (exp_valid_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: sticker_index=%0d at cycle %0d, none required", sticker_index, cyc);
            end else begin
                ve = exp_valid_q.pop_front();
                check("valid_index", 64'(sticker_index), 64'(ve.idx));
                check("valid_cycle", 64'(cyc), 64'(ve.cyc));
                check("valid_cube", 64'(cubestate), 64'(ve.cube));
            end
        end
    end

    // Plays motor and sensors for one sticker. status: 0 accepted,
    // 1 timed out, 2 reset applied, 3 bench bound expired.
    task automatic do_sticker(input int i, input int mode, output int status);
        int  seq [T_OUT];
        int  p, d, sb_c, val, n, ch, tgt, j, selv, otherv, found;
        bit  lost;
        logic [CS_W-1:0] cs;
        status = 3;
        found  = 0;
        for (int k = 0; k < 60 && found == 0; k++) begin
            @(negedge clock);
            start        = 1'b0;
            done_turning = 1'b0;
            if (send_setup_moves) found = 1;
        end
        n_checks++;
        if (found == 0) begin
            n_fail++;
            $display("FAIL pulse_wait: no send_setup_moves for sticker %0d within 60 cycles", i);
            return;
        end
        p = cyc;
        if (i == 0) begin
            check("restart_error_clear", 64'(scan_error), 64'd0);
            check("restart_done_clear", 64'(scan_done), 64'd0);
            check("restart_busy", 64'(busy), 64'd1);
            check("restart_cube_clear", 64'(cubestate), 64'd0);
        end
        ch  = i / SPS;
        tgt = int'($urandom_range(5, 0));
        for (int k = 0; k < T_OUT; k++) begin
            case (mode)
                M_DIR:   seq[k] = (ch == 0) ? 1 : 4;
                M_NOISY: seq[k] = noisy_seq[k];
                M_TMO:   seq[k] = k % 2;
                M_RAND:  seq[k] = ($urandom_range(3, 0) != 0) ? tgt : int'($urandom_range(7, 0));
                default: seq[k] = tgt;
            endcase
        end
        lost = 1'b0;
        sb_c = -100;
        if (mode == M_DIR) begin
            d = p + 5;
        end else begin
            lost = ($urandom_range(3, 0) == 0);
            d = p + (lost ? int'($urandom_range(6, 2)) : int'($urandom_range(6, 1)));
            if (d >= p + 3 && $urandom_range(1, 0) == 1) sb_c = p + 2;
        end
        // A done_turning during the request cycle must be lost.
        if (lost) done_turning = 1'b1;
        model_eval(seq, val, n);
        if (mode != M_RST && n > 0) begin
            model_cube[i] = val;
            exp_valid_q.push_back('{idx: i, cyc: d + 3 + n, cube: build_cube()});
            if (i < NS - 1) exp_pulse_q.push_back('{idx: i + 1, cyc: d + 4 + n});
        end
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            done_turning = (cyc == d);
            start        = (cyc == sb_c);
            reset        = (mode == M_RST && cyc == d + 1);
            j = cyc - (d + 3);
            if (j >= 0 && j < T_OUT) selv = seq[j];
            else selv = (mode == M_DIR) ? seq[0] : int'($urandom_range(7, 0));
            otherv = (mode == M_DIR) ? ((ch == 0) ? 4 : 1) : int'($urandom_range(7, 0));
            for (int c = 0; c < N_SENS; c++) cs[c*C_W +: C_W] = C_W'((c == ch) ? selv : otherv);
            color_sensors = cs;
            if (cyc == sb_c + 1) begin
                check("busy_start_index", 64'(sticker_index), 64'(i));
                check("busy_start_busy", 64'(busy), 64'd1);
            end
            if (mode == M_RST && cyc == d + 2) begin
                check("rst_send", 64'(send_setup_moves), 64'd0);
                check("rst_setup_index", 64'(setup_index), 64'd0);
                check("rst_valid", 64'(sticker_valid), 64'd0);
                check("rst_index", 64'(sticker_index), 64'd0);
                check("rst_cube", 64'(cubestate), 64'd0);
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_done", 64'(scan_done), 64'd0);
                check("rst_error", 64'(scan_error), 64'd0);
                exp_pulse_q.delete();
                exp_valid_q.delete();
                status = 2;
                return;
            end
            if (mode != M_RST && n > 0 && cyc == d + 3 + n) begin
                status = 0;
                return;
            end
            if (mode != M_RST && n == 0) begin
                if (cyc == d + 2 + T_OUT) check("tmo_not_early", 64'(scan_error), 64'd0);
                if (cyc == d + 3 + T_OUT) begin
                    check("tmo_error", 64'(scan_error), 64'd1);
                    check("tmo_busy", 64'(busy), 64'd0);
                    check("tmo_index_frozen", 64'(sticker_index), 64'(i));
                    check("tmo_cube_frozen", 64'(cubestate), 64'(build_cube()));
                    status = 1;
                    return;
                end
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL sticker_bound: sticker %0d did not finish within 200 cycles", i);
    endtask

    task automatic run_scan(input int sel);
        int st, mode;
        @(negedge clock);
        start = 1'b1;
        exp_pulse_q.push_back('{idx: 0, cyc: cyc + 1});
        for (int i = 0; i < NS; i++) model_cube[i] = 0;
        for (int i = 0; i < NS; i++) begin
            case (sel)
                0:       mode = M_DIR;
                1:       mode = (i == 0) ? M_NOISY : M_RAND;
                2:       mode = (i == 1) ? M_TMO : M_CLEAN;
                3:       mode = (i == 2) ? M_RST : M_CLEAN;
                default: mode = M_RAND;
            endcase
            do_sticker(i, mode, st);
            if (st != 0) break;
            if (i == NS - 1) begin
                @(negedge clock);
                check("end_scan_done", 64'(scan_done), 64'd1);
                check("end_busy", 64'(busy), 64'd0);
                check("end_scan_error", 64'(scan_error), 64'd0);
                check("end_cube", 64'(cubestate), 64'(build_cube()));
                if (sel == 0) check("directed_cube", 64'(cubestate), 64'h909);
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        done_turning  = 1'b0;
        color_sensors = '0;
        repeat (3) @(negedge clock);
        check("reset_send", 64'(send_setup_moves), 64'd0);
        check("reset_setup_index", 64'(setup_index), 64'd0);
        check("reset_valid", 64'(sticker_valid), 64'd0);
        check("reset_index", 64'(sticker_index), 64'd0);
        check("reset_cube", 64'(cubestate), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(scan_done), 64'd0);
        check("reset_error", 64'(scan_error), 64'd0);
        reset = 1'b0;

        run_scan(0);
        run_scan(1);
        run_scan(2);
        run_scan(3);
        repeat (20) @(negedge clock);
        check("post_reset_idle_busy", 64'(busy), 64'd0);
        check("post_reset_idle_done", 64'(scan_done), 64'd0);
        for (int r = 0; r < 6; r++) run_scan(4);
        repeat (3) @(negedge clock);
        check("pulse_queue_empty", 64'(exp_pulse_q.size()), 64'd0);
        check("valid_queue_empty", 64'(exp_valid_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
